irrigation_sequencer: RTL and testbench

Clocked controller that sequences the tank and field valves of the irrigation system. It debounces the three tank-level sensors and detects inconsistent sensor combinations. It runs a timed irrigation state machine that selects sprinkler or drip, enforces a minimum on-time and a cooldown, and controls the inlet valve with hysteresis. It sits between the raw sensor pins and the valve drivers and 7-segment display path, and replaces free-running combinational valve decode with registered, glitch-free control.

---
 rtl/irrigation_sequencer.sv | 177 +++++++++++++++++
 tb/tb_irrigation_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_sequencer.sv
// Irrigation sequencer: debounced tank levels, timed sprinkler/drip runs with
// cooldown and fault hold, plus a hysteretic inlet valve. All outputs registered.
module irrigation_sequencer #(
    parameter int unsigned DEBOUNCE = 16,
    parameter int unsigned MIN_ON   = 1000,
    parameter int unsigned COOLDOWN = 500,
    parameter int unsigned ERR_HOLD = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       high,
    input  logic       middle,
    input  logic       low,
    input  logic       umidadeDoSolo,
    input  logic       umidadeDoAr,
    input  logic       temperatura,
    output logic       erro,
    output logic       saidaDoAlarme,
    output logic       ValvulaDeEntrada,
    output logic       ValvulaDeAspersao,
    output logic       ValvulaDeGotejamento,
    output logic [2:0] estado
);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE + 1);
    localparam int unsigned ON_W   = (MIN_ON > 1) ? $clog2(MIN_ON) : 1;
    localparam int unsigned COOL_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam int unsigned HOLD_W = $clog2(ERR_HOLD + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [ON_W-1:0]   ON_LAST   = ON_W'(MIN_ON - 1);
    localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ERR_HOLD - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SPRINKLE = 3'd1,
        ST_DRIP     = 3'd2,
        ST_COOL     = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    state_t state;

    // level bit order: [2]=high, [1]=middle, [0]=low
    logic [2:0]        s_lvl;
    logic [2:0]        filt_lvl;
    logic [DB_W-1:0]   db_cnt [3];
    logic              s_soil, s_air, s_temp;
    logic [ON_W-1:0]   on_cnt;
    logic [COOL_W-1:0] cool_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    logic filt_high, filt_middle, filt_low;
    logic erro_comb, alarm_comb, drip_sel, run_level, fault_next;

    assign filt_high   = filt_lvl[2];
    assign filt_middle = filt_lvl[1];
    assign filt_low    = filt_lvl[0];

    assign erro_comb  = (filt_high & ~filt_middle) | (filt_middle & ~filt_low);
    assign alarm_comb = erro_comb | ~filt_low;
    assign drip_sel   = s_temp & ~s_air;
    assign run_level  = (state == ST_DRIP) ? filt_low : filt_middle;
    assign fault_next = erro_comb | ((state == ST_FAULT) & (hold_cnt != HOLD_LAST));

    // Input registers and level debouncers
    always_ff @(posedge clock) begin
        if (reset) begin
            s_lvl    <= '0;
            s_soil   <= 1'b0;
            s_air    <= 1'b0;
            s_temp   <= 1'b0;
            filt_lvl <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            s_lvl  <= {high, middle, low};
            s_soil <= umidadeDoSolo;
            s_air  <= umidadeDoAr;
            s_temp <= temperatura;
            for (int i = 0; i < 3; i++) begin
                if (s_lvl[i] == filt_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt_lvl[i] <= ~filt_lvl[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            erro          <= 1'b0;
            saidaDoAlarme <= 1'b0;
        end else begin
            erro          <= erro_comb;
            saidaDoAlarme <= alarm_comb;
        end
    end

    // Inlet valve hysteresis: open below middle, close at high, shut in fault
    always_ff @(posedge clock) begin
        if (reset || fault_next) begin
            ValvulaDeEntrada <= 1'b0;
        end else if (!filt_middle) begin
            ValvulaDeEntrada <= 1'b1;
        end else if (filt_high) begin
            ValvulaDeEntrada <= 1'b0;
        end
    end

    // Sequencing FSM; valves and estado are registered with the state
    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= ST_IDLE;
            estado               <= ST_IDLE;
            ValvulaDeAspersao    <= 1'b0;
            ValvulaDeGotejamento <= 1'b0;
            on_cnt               <= '0;
            cool_cnt             <= '0;
            hold_cnt             <= '0;
        end else if (erro_comb) begin
            state                <= ST_FAULT;
            estado               <= ST_FAULT;
            ValvulaDeAspersao    <= 1'b0;
            ValvulaDeGotejamento <= 1'b0;
            hold_cnt             <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!s_soil && !alarm_comb && (drip_sel ? filt_low : filt_middle)) begin
                        state                <= drip_sel ? ST_DRIP : ST_SPRINKLE;
                        estado               <= drip_sel ? ST_DRIP : ST_SPRINKLE;
                        ValvulaDeAspersao    <= ~drip_sel;
                        ValvulaDeGotejamento <= drip_sel;
                        on_cnt               <= '0;
                    end
                end
                ST_SPRINKLE, ST_DRIP: begin
                    if (alarm_comb || !run_level || (s_soil && on_cnt >= ON_LAST)) begin
                        state                <= ST_COOL;
                        estado               <= ST_COOL;
                        ValvulaDeAspersao    <= 1'b0;
                        ValvulaDeGotejamento <= 1'b0;
                        cool_cnt             <= '0;
                    end else if (on_cnt != ON_LAST) begin
                        on_cnt <= on_cnt + ON_W'(1);
                    end
                end
                ST_COOL: begin
                    if (cool_cnt == COOL_LAST) begin
                        state  <= ST_IDLE;
                        estado <= ST_IDLE;
                    end else begin
                        cool_cnt <= cool_cnt + COOL_W'(1);
                    end
                end
                ST_FAULT: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state  <= ST_IDLE;
                        estado <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state                <= ST_IDLE;
                    estado               <= ST_IDLE;
                    ValvulaDeAspersao    <= 1'b0;
                    ValvulaDeGotejamento <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_irrigation_sequencer.sv
// Bench for irrigation_sequencer: scripted vector table, timed corner sequences,
// then random stimulus against a cycle-level reference model.
module tb_irrigation_sequencer;
    localparam int unsigned DEBOUNCE = 4;
    localparam int unsigned MIN_ON   = 8;
    localparam int unsigned COOLDOWN = 5;
    localparam int unsigned ERR_HOLD = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       high = 1'b0, middle = 1'b0, low = 1'b0;
    logic       soil = 1'b0, air = 1'b0, temp = 1'b0;
    logic       erro, alarme, entrada, aspersao, gotejamento;
    logic [2:0] estado;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    irrigation_sequencer #(
        .DEBOUNCE(DEBOUNCE),
        .MIN_ON  (MIN_ON),
        .COOLDOWN(COOLDOWN),
        .ERR_HOLD(ERR_HOLD)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .high                (high),
        .middle              (middle),
        .low                 (low),
        .umidadeDoSolo       (soil),
        .umidadeDoAr         (air),
        .temperatura         (temp),
        .erro                (erro),
        .saidaDoAlarme       (alarme),
        .ValvulaDeEntrada    (entrada),
        .ValvulaDeAspersao   (aspersao),
        .ValvulaDeGotejamento(gotejamento),
        .estado              (estado)
    );

    // Reference model: levels indexed [2]=high [1]=middle [0]=low; states 0..4
    bit [2:0] ms_lvl, mf_lvl;
    bit       ms_soil, ms_air, ms_temp;
    int       streak [3];
    int       m_st, m_age, m_clean;
    bit       m_in, m_erro, m_alarm;

    function automatic void model_step();
        bit ec, ac, need, drip;
        int nxt;
        if (reset) begin
            ms_lvl = '0; mf_lvl = '0;
            ms_soil = 1'b0; ms_air = 1'b0; ms_temp = 1'b0;
            for (int i = 0; i < 3; i++) streak[i] = 0;
            m_st = 0; m_age = 0; m_clean = 0;
            m_in = 1'b0; m_erro = 1'b0; m_alarm = 1'b0;
            return;
        end
        ec = (mf_lvl[2] && !mf_lvl[1]) || (mf_lvl[1] && !mf_lvl[0]);
        ac = ec || !mf_lvl[0];
        nxt = m_st;
        if (ec) begin
            nxt = 4;
        end else begin
            case (m_st)
                0: begin
                    drip = ms_temp && !ms_air;
                    if (!ms_soil && !ac && (drip ? mf_lvl[0] : mf_lvl[1])) nxt = drip ? 2 : 1;
                end
                1, 2: begin
                    need = (m_st == 2) ? mf_lvl[0] : mf_lvl[1];
                    if (ac || !need || (ms_soil && m_age + 1 >= int'(MIN_ON))) nxt = 3;
                end
                3: if (m_age + 1 >= int'(COOLDOWN)) nxt = 0;
                4: if (m_clean + 1 >= int'(ERR_HOLD)) nxt = 0;
                default: nxt = 0;
            endcase
        end
        m_clean = (m_st == 4 && !ec) ? m_clean + 1 : 0;
        m_age   = (nxt == m_st) ? m_age + 1 : 0;
        if (nxt == 4) m_in = 1'b0;
        else if (!mf_lvl[1]) m_in = 1'b1;
        else if (mf_lvl[2]) m_in = 1'b0;
        m_erro  = ec;
        m_alarm = ac;
        m_st    = nxt;
        for (int i = 0; i < 3; i++) begin
            if (ms_lvl[i] == mf_lvl[i]) begin
                streak[i] = 0;
            end else begin
                streak[i]++;
                if (streak[i] == int'(DEBOUNCE)) begin
                    mf_lvl[i] = ~mf_lvl[i];
                    streak[i] = 0;
                end
            end
        end
        ms_lvl  = {high, middle, low};
        ms_soil = soil;
        ms_air  = air;
        ms_temp = temp;
    endfunction

    function automatic logic [7:0] model_out();
        return {m_erro, m_alarm, m_in, 1'(m_st == 1), 1'(m_st == 2), 3'(m_st)};
    endfunction

    function automatic logic [7:0] dut_out();
        return {erro, alarme, entrada, aspersao, gotejamento, estado};
    endfunction

    function automatic void check(string name, logic [7:0] act, logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got {erro,alarm,in,asp,got,est}=%b want %b",
                     name, $time, act, req);
        end
    endfunction

    function automatic void check_int(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check("model", dut_out(), model_out());
    endtask

    typedef struct {
        logic       rst;
        logic [2:0] lvl;   // {high, middle, low}
        logic       soil, air, temp;
        int         n;     // edges to apply before comparing
        logic [7:0] req;   // {erro, alarm, inlet, sprinkler, drip, estado}
    } vec_t;

    function automatic vec_t mk(logic r, logic [2:0] l, logic s, logic a, logic t, int n,
                                logic e, logic al, logic vi, logic va, logic vg, logic [2:0] st);
        vec_t v;
        v.rst = r; v.lvl = l; v.soil = s; v.air = a; v.temp = t; v.n = n;
        v.req = {e, al, vi, va, vg, st};
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[$];
        int   run_len, cool_len;

        //                rst lvl    soil air temp n   erro al in asp got est
        vt.push_back(mk(1, 3'b000, 0, 0, 0, 3,  0, 0, 0, 0, 0, 3'd0)); // in reset
        vt.push_back(mk(0, 3'b000, 0, 0, 0, 1,  0, 1, 1, 0, 0, 3'd0)); // first edge after release
        vt.push_back(mk(0, 3'b011, 1, 0, 0, 5,  0, 1, 1, 0, 0, 3'd0)); // level still filtering
        vt.push_back(mk(0, 3'b011, 1, 0, 0, 1,  0, 0, 1, 0, 0, 3'd0)); // alarm clears at DEBOUNCE+2
        vt.push_back(mk(0, 3'b111, 1, 0, 0, 3,  0, 0, 1, 0, 0, 3'd0)); // 3-cycle high glitch
        vt.push_back(mk(0, 3'b011, 1, 0, 0, 5,  0, 0, 1, 0, 0, 3'd0)); // glitch rejected
        vt.push_back(mk(0, 3'b111, 1, 0, 0, 5,  0, 0, 1, 0, 0, 3'd0)); // held high, edge 5
        vt.push_back(mk(0, 3'b111, 1, 0, 0, 1,  0, 0, 0, 0, 0, 3'd0)); // inlet closes edge 6
        vt.push_back(mk(0, 3'b111, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3'd0)); // soil dry, 1 edge
        vt.push_back(mk(0, 3'b111, 0, 0, 0, 1,  0, 0, 0, 1, 0, 3'd1)); // sprinkle after 2 edges
        vt.push_back(mk(0, 3'b111, 0, 0, 0, 1,  0, 0, 0, 1, 0, 3'd1));
        vt.push_back(mk(0, 3'b111, 1, 0, 0, 6,  0, 0, 0, 1, 0, 3'd1)); // wet soil, still min-on
        vt.push_back(mk(0, 3'b111, 1, 0, 0, 1,  0, 0, 0, 0, 0, 3'd3)); // 8 cycles done
        vt.push_back(mk(0, 3'b111, 1, 0, 0, 4,  0, 0, 0, 0, 0, 3'd3));
        vt.push_back(mk(0, 3'b111, 1, 0, 0, 1,  0, 0, 0, 0, 0, 3'd0)); // cooldown of 5
        vt.push_back(mk(0, 3'b001, 1, 0, 1, 6,  0, 0, 1, 0, 0, 3'd0)); // only low, inlet opens
        vt.push_back(mk(0, 3'b001, 0, 0, 1, 2,  0, 0, 1, 0, 1, 3'd2)); // drip selected
        vt.push_back(mk(0, 3'b000, 0, 0, 1, 5,  0, 0, 1, 0, 1, 3'd2)); // low dropping
        vt.push_back(mk(0, 3'b000, 0, 0, 1, 1,  0, 1, 1, 0, 0, 3'd3)); // abort before MIN_ON
        vt.push_back(mk(0, 3'b000, 0, 0, 1, 5,  0, 1, 1, 0, 0, 3'd0));
        vt.push_back(mk(0, 3'b001, 0, 0, 1, 5,  0, 1, 1, 0, 0, 3'd0));
        vt.push_back(mk(0, 3'b001, 0, 0, 1, 1,  0, 0, 1, 0, 1, 3'd2)); // drip again
        vt.push_back(mk(0, 3'b101, 0, 0, 1, 5,  0, 0, 1, 0, 1, 3'd2)); // high without middle
        vt.push_back(mk(0, 3'b101, 0, 0, 1, 1,  1, 1, 0, 0, 0, 3'd4)); // fault after 6 edges
        vt.push_back(mk(0, 3'b001, 1, 0, 1, 2,  1, 1, 0, 0, 0, 3'd4)); // clear high
        vt.push_back(mk(0, 3'b010, 1, 0, 1, 4,  0, 0, 0, 0, 0, 3'd4)); // recovered, holding
        vt.push_back(mk(0, 3'b010, 1, 0, 1, 2,  1, 1, 0, 0, 0, 3'd4)); // error recurs, restart
        vt.push_back(mk(0, 3'b001, 1, 0, 1, 7,  0, 0, 0, 0, 0, 3'd4)); // 2 clean cycles so far
        vt.push_back(mk(0, 3'b001, 1, 0, 1, 1,  0, 0, 1, 0, 0, 3'd0)); // IDLE after 3 clean
        vt.push_back(mk(0, 3'b001, 0, 0, 1, 2,  0, 0, 1, 0, 1, 3'd2)); // start a run
        vt.push_back(mk(1, 3'b001, 0, 0, 1, 1,  0, 0, 0, 0, 0, 3'd0)); // reset mid-run
        vt.push_back(mk(0, 3'b000, 1, 0, 0, 1,  0, 1, 1, 0, 0, 3'd0));

        foreach (vt[k]) begin
            reset = vt[k].rst;
            {high, middle, low} = vt[k].lvl;
            soil = vt[k].soil; air = vt[k].air; temp = vt[k].temp;
            repeat (vt[k].n) tick();
            check($sformatf("vec%0d", k), dut_out(), vt[k].req);
        end

        // Run and cooldown lengths when soil turns wet right after entry
        {high, middle, low} = 3'b111; soil = 1'b1; temp = 1'b0; air = 1'b0;
        repeat (8) tick();
        soil = 1'b0;
        tick();
        soil = 1'b1;
        run_len = 0;
        cool_len = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (aspersao) run_len++;
            if (estado == 3'd3) cool_len++;
            else if (cool_len > 0) break;
        end
        check_int("run_length", run_len, int'(MIN_ON));
        check_int("cooldown_length", cool_len, int'(COOLDOWN));

        // Reset during a sprinkler run closes every valve on the next edge
        soil = 1'b0;
        repeat (2) tick();
        check("run_before_reset", dut_out(), 8'b0001_0001);
        reset = 1'b1;
        tick();
        check("reset_closes_valves", dut_out(), 8'b0000_0000);
        reset = 1'b0;

        // Random stimulus against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 11) == 0) high   = ~high;
            if ($urandom_range(0, 11) == 0) middle = ~middle;
            if ($urandom_range(0, 11) == 0) low    = ~low;
            if ($urandom_range(0, 14) == 0) soil   = ~soil;
            if ($urandom_range(0, 9) == 0)  air    = ~air;
            if ($urandom_range(0, 9) == 0)  temp   = ~temp;
            reset = ($urandom_range(0, 799) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
